seq_det_ctrl: RTL and testbench
===============================

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter PAT_W, default 8: maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 8: width of the hit counter and hit limit.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: single-cycle request that loads the configuration and arms detection.
REQ-006 Port abort, input, 1: terminates an armed session.
REQ-007 Port pat, input, PAT_W: pattern to detect; bit 0 is the newest sample.
REQ-008 Port pat_len, input, clog2(PAT_W+1): active pattern length.
REQ-009 Port max_hits, input, CNT_W: hit limit; 0 means unlimited.
REQ-010 Port x, input, 1: serial data bit.
REQ-011 Port x_valid, input, 1: x is sampled only when x_valid is high.
REQ-012 Port y, output, 1: one-cycle match pulse.
REQ-013 Port busy, output, 1: high while in ARMED.
REQ-014 Port done, output, 1: one-cycle pulse when the hit limit is reached.
REQ-015 Port hit_cnt, output, CNT_W: matches counted in the current or last session.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ARMED and DONE.
REQ-017 In IDLE, start=1 SHALL latch pat, pat_len and max_hits; clear hit_cnt, the history register and the valid-sample count; and enter ARMED next cycle.
REQ-018 Latched pat_len values SHALL be clamped: 0 becomes 1, and values above PAT_W become PAT_W.
REQ-019 start SHALL be ignored in ARMED and in DONE.
REQ-020 In ARMED, each cycle with x_valid=1 SHALL shift x into the history LSB; the valid-sample count increments, saturating at PAT_W.
REQ-021 A match SHALL occur on a sampled cycle when valid count >= pat_len and the low pat_len bits of history (including the new x) equal the low pat_len bits of pat.
REQ-022 y SHALL be registered and pulse for exactly one cycle, in the cycle after the sample that completes the match.
REQ-023 hit_cnt SHALL increment in the same cycle y is high.
REQ-024 When max_hits = 0, hit_cnt SHALL saturate at all-ones.
REQ-025 Cycles with x_valid=0 SHALL neither shift, match nor change the valid count.
REQ-026 When max_hits != 0 and a match brings hit_cnt to max_hits, the FSM SHALL enter DONE, asserting done for one cycle, then return to IDLE.
REQ-027 In ARMED, abort=1 SHALL return the FSM to IDLE next cycle with no done pulse; hit_cnt SHALL hold.
REQ-028 When abort coincides with a match, y SHALL still pulse and hit_cnt SHALL still increment; abort wins the state transition, and done SHALL NOT pulse.
REQ-029 hit_cnt SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-030 On rst=1 the FSM SHALL go immediately to IDLE, and y, busy, done, hit_cnt, history, valid count and all latched configuration SHALL clear to 0, including mid-session.

Configuration
REQ-031 With macro SEQ_DET_OVERLAP_EN defined, history and valid count SHALL be preserved after a match, so overlapping matches are detected.
REQ-032 Without SEQ_DET_OVERLAP_EN, the valid count SHALL clear to 0 on a match, so the next match requires pat_len fresh samples.

Structure
REQ-033 A package seq_det_pkg SHALL hold the state enum (IDLE, ARMED, DONE) and the default PAT_W/CNT_W constants.
REQ-034 The shift and compare logic SHALL be a sub-module seq_det_match; seq_det_ctrl owns the FSM, the hit counter and the configuration latches.

Verification
REQ-035 pat=3'b101, pat_len=3, max_hits=0, overlap enabled, x stream 0,1,1,1,0,1,0,0,1,0,1,0,1 (all valid) -> y pulses after samples 5, 10 and 12; hit_cnt=3.
REQ-036 Same stimulus without SEQ_DET_OVERLAP_EN -> y pulses after samples 5 and 10 only; hit_cnt=2.
REQ-037 max_hits=2, same stream with overlap -> done pulses once, one cycle after the second y; busy falls; the third 101 is not counted; hit_cnt=2.
REQ-038 x_valid held low between stream bits 1 and 0 of a 101 -> the match still fires; y never asserts on invalid cycles.
REQ-039 abort asserted on the cycle of a completing match -> y=1, hit_cnt increments, done=0, FSM in IDLE next cycle.
REQ-040 rst pulsed mid-session with hit_cnt=2 -> all outputs are 0 without waiting for a clock edge; a subsequent start works normally.

Source files
------------

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared types and default sizing for the serial sequence detector.
//   state_e    : controller FSM states (IDLE, ARMED, DONE)
//   PAT_W_DEF  : default maximum pattern length in bits
//   CNT_W_DEF  : default width of the hit counter / hit limit
// -----------------------------------------------------------------------------
package seq_det_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_det_if.sv
// -----------------------------------------------------------------------------
// seq_det_if
// Control/data bundle between a stimulus source (master) and seq_det_ctrl
// (slave). Suffixes are from the detector's point of view.
//   start_i    : single-cycle request, loads configuration and arms detection
//   abort_i    : ends an armed session without a done pulse
//   pat_i      : pattern, bit 0 is the newest sample
//   pat_len_i  : active pattern length (clamped to 1..PAT_W inside)
//   max_hits_i : hit limit, 0 = unlimited
//   x_i        : serial data bit, sampled only when x_valid_i is high
//   y_o        : one-cycle match pulse
//   busy_o     : high while a session is armed
//   done_o     : one-cycle pulse after the hit limit is reached
//   hit_cnt_o  : matches counted in the current or last session
// -----------------------------------------------------------------------------
interface seq_det_if #(
    parameter int PAT_W = seq_det_pkg::PAT_W_DEF,
    parameter int CNT_W = seq_det_pkg::CNT_W_DEF
) ();

    localparam int LEN_W = $clog2(PAT_W + 1);

    logic                start_i;
    logic                abort_i;
    logic [PAT_W-1:0]    pat_i;
    logic [LEN_W-1:0]    pat_len_i;
    logic [CNT_W-1:0]    max_hits_i;
    logic                x_i;
    logic                x_valid_i;
    logic                y_o;
    logic                busy_o;
    logic                done_o;
    logic [CNT_W-1:0]    hit_cnt_o;

    modport master (
        output start_i, abort_i, pat_i, pat_len_i, max_hits_i, x_i, x_valid_i,
        input  y_o, busy_o, done_o, hit_cnt_o
    );

    modport slave (
        input  start_i, abort_i, pat_i, pat_len_i, max_hits_i, x_i, x_valid_i,
        output y_o, busy_o, done_o, hit_cnt_o
    );

endinterface

// File: rtl/seq_det_match.sv
// -----------------------------------------------------------------------------
// seq_det_match
// Sample history shift register, saturating valid-sample count and the
// masked pattern compare. match_o is combinational for the current sample;
// the controller registers it.
// Build option: SEQ_DET_OVERLAP_EN -- when defined, the valid count is kept
// after a match so overlapping occurrences are detected; otherwise it is
// cleared so each match needs pat_len fresh samples.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clr_i       : clear history and valid count (session start)
//   en_i        : detection enabled (controller ARMED)
//   x_i         : serial data bit
//   x_valid_i   : sample qualifier
//   pat_i       : latched pattern
//   pat_len_i   : latched, clamped pattern length (1..PAT_W)
//   match_o     : current sample completes a match
// -----------------------------------------------------------------------------
module seq_det_match
    import seq_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         en_i,
    input  logic                         x_i,
    input  logic                         x_valid_i,
    input  logic [PAT_W-1:0]             pat_i,
    input  logic [$clog2(PAT_W+1)-1:0]   pat_len_i,
    output logic                         match_o
);

    localparam int LEN_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] hist_d;
    logic [PAT_W-1:0] hist_shift_s;
    logic [PAT_W-1:0] mask_s;
    logic [LEN_W-1:0] vcnt_q;
    logic [LEN_W-1:0] vcnt_d;
    logic [LEN_W-1:0] vcnt_inc_s;
    logic             sample_s;
    logic             match_s;

    // Low 'len' bits set: selects the part of history/pattern that is compared.
    function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [PAT_W-1:0] m;
        m = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < int'(len)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    // Compare the history including the new sample against the pattern.
    always_comb begin
        sample_s     = en_i & x_valid_i;
        hist_shift_s = {hist_q[PAT_W-2:0], x_i};
        mask_s       = len_mask(pat_len_i);
        if (vcnt_q == LEN_W'(PAT_W)) begin
            vcnt_inc_s = vcnt_q;
        end else begin
            vcnt_inc_s = vcnt_q + LEN_W'(1);
        end
        match_s = sample_s
                  & (vcnt_inc_s >= pat_len_i)
                  & ((hist_shift_s & mask_s) == (pat_i & mask_s));
    end

    // Next-state for history and valid count.
    always_comb begin
        hist_d = hist_q;
        vcnt_d = vcnt_q;
        if (clr_i) begin
            hist_d = '0;
            vcnt_d = '0;
        end else if (sample_s) begin
            hist_d = hist_shift_s;
`ifdef SEQ_DET_OVERLAP_EN
            vcnt_d = vcnt_inc_s;
`else
            if (match_s) begin
                vcnt_d = '0;
            end else begin
                vcnt_d = vcnt_inc_s;
            end
`endif
        end else begin
            hist_d = hist_q;
            vcnt_d = vcnt_q;
        end
    end

    // History and valid-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            vcnt_q <= '0;
        end else begin
            hist_q <= hist_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign match_o = match_s;

endmodule

// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
// Serial pattern detector controller: FSM (IDLE/ARMED/DONE), configuration
// latches, hit counter and registered outputs. Shift/compare lives in
// seq_det_match.
// Build option: SEQ_DET_OVERLAP_EN (see seq_det_match) enables overlapping
// match detection; the default build uses non-overlapping detection.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   ctrl_if  : seq_det_if.slave bundle (start/abort/config/x in, y/busy/done/
//              hit_cnt out)
// -----------------------------------------------------------------------------
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic     clk,
    input  logic     rst,
    seq_det_if.slave ctrl_if
);

    localparam int LEN_W = $clog2(PAT_W + 1);

    state_e           state_q;
    state_e           state_d;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] pat_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic [CNT_W-1:0] max_q;
    logic [CNT_W-1:0] max_d;
    logic [CNT_W-1:0] hit_q;
    logic [CNT_W-1:0] hit_d;
    logic             y_q;
    logic             y_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;
    logic             armed_s;
    logic             start_ok_s;
    logic             match_s;
    logic             limit_s;

    // Pattern length 0 is treated as 1, anything above PAT_W as PAT_W.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] r;
        if (len == '0) begin
            r = LEN_W'(1);
        end else if (len > LEN_W'(PAT_W)) begin
            r = LEN_W'(PAT_W);
        end else begin
            r = len;
        end
        return r;
    endfunction

    seq_det_match #(
        .PAT_W (PAT_W)
    ) u_match (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (start_ok_s),
        .en_i      (armed_s),
        .x_i       (ctrl_if.x_i),
        .x_valid_i (ctrl_if.x_valid_i),
        .pat_i     (pat_q),
        .pat_len_i (len_q),
        .match_o   (match_s)
    );

    // Session qualifiers; the limit is hit when this match makes hit_cnt == max_hits.
    always_comb begin
        armed_s    = (state_q == ARMED);
        start_ok_s = (state_q == IDLE) & ctrl_if.start_i;
        limit_s    = (max_q != '0) & (hit_q == (max_q - CNT_W'(1)));
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; abort takes priority over reaching the limit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ctrl_if.start_i) begin
                    state_d = ARMED;
                end else begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                if (ctrl_if.abort_i) begin
                    state_d = IDLE;
                end else if (match_s && limit_s) begin
                    state_d = DONE;
                end else begin
                    state_d = ARMED;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; done follows the DONE state by one cycle, i.e. one cycle after the last y.
    always_comb begin
        y_d    = armed_s & match_s;
        busy_d = (state_d == ARMED);
        done_d = (state_q == DONE);
    end

    // Configuration latch and hit counter next-state.
    always_comb begin
        pat_d = pat_q;
        len_d = len_q;
        max_d = max_q;
        hit_d = hit_q;
        if (start_ok_s) begin
            pat_d = ctrl_if.pat_i;
            len_d = clamp_len(ctrl_if.pat_len_i);
            max_d = ctrl_if.max_hits_i;
            hit_d = '0;
        end else if (armed_s && match_s) begin
            if (hit_q == {CNT_W{1'b1}}) begin
                hit_d = hit_q;
            end else begin
                hit_d = hit_q + CNT_W'(1);
            end
        end else begin
            hit_d = hit_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= '0;
            len_q  <= '0;
            max_q  <= '0;
            hit_q  <= '0;
            y_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            max_q  <= max_d;
            hit_q  <= hit_d;
            y_q    <= y_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign ctrl_if.y_o       = y_q;
    assign ctrl_if.busy_o    = busy_q;
    assign ctrl_if.done_o    = done_q;
    assign ctrl_if.hit_cnt_o = hit_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_det_ctrl
// Directed testbench for seq_det_ctrl (PAT_W=8, CNT_W=8). Expected values are
// hand-derived per step; overlap-dependent expectations follow
// SEQ_DET_OVERLAP_EN.
// -----------------------------------------------------------------------------
module tb_seq_det_ctrl;

`ifdef SEQ_DET_OVERLAP_EN
    localparam bit OV = 1'b1;
`else
    localparam bit OV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_det_if #(.PAT_W(8), .CNT_W(8)) sif ();

    seq_det_ctrl #(
        .PAT_W (8),
        .CNT_W (8)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (sif.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    bit stream_a [0:12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                            1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        sif.start_i    = 1'b0;
        sif.abort_i    = 1'b0;
        sif.x_i        = 1'b0;
        sif.x_valid_i  = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] p, input logic [3:0] l, input logic [7:0] m);
        sif.pat_i      = p;
        sif.pat_len_i  = l;
        sif.max_hits_i = m;
        sif.start_i    = 1'b1;
        step();
        sif.start_i    = 1'b0;
    endtask

    task automatic smp(input logic xv, input logic vv);
        sif.x_i       = xv;
        sif.x_valid_i = vv;
        step();
        sif.x_valid_i = 1'b0;
    endtask

    task automatic do_abort();
        sif.abort_i = 1'b1;
        step();
        sif.abort_i = 1'b0;
    endtask

    initial begin
        logic       ey;
        logic [7:0] eh;
        logic [7:0] a5;
        bit         t3_x [0:4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bit         t3_v [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // ---- reset state ----
        rst = 1'b1;
        idle_in();
        sif.pat_i      = 8'h00;
        sif.pat_len_i  = 4'd0;
        sif.max_hits_i = 8'd0;
        #12;
        check_eq("rst_y",    {31'd0, sif.y_o},    32'd0);
        check_eq("rst_busy", {31'd0, sif.busy_o}, 32'd0);
        check_eq("rst_done", {31'd0, sif.done_o}, 32'd0);
        check_eq("rst_hit",  {24'd0, sif.hit_cnt_o}, 32'd0);
        rst = 1'b0;
        step();

        // ---- T1: 101 stream, unlimited hits ----
        do_start(8'h05, 4'd3, 8'd0);
        check_eq("t1_busy0", {31'd0, sif.busy_o}, 32'd1);
        check_eq("t1_hit0",  {24'd0, sif.hit_cnt_o}, 32'd0);
        eh = 8'd0;
        for (int i = 0; i < 13; i++) begin
            smp(stream_a[i], 1'b1);
            ey = (i == 5) || (i == 10) || (OV && (i == 12));
            eh = eh + {7'd0, ey};
            check_eq($sformatf("t1_y[%0d]", i),   {31'd0, sif.y_o},      {31'd0, ey});
            check_eq($sformatf("t1_hit[%0d]", i), {24'd0, sif.hit_cnt_o}, {24'd0, eh});
            check_eq($sformatf("t1_done[%0d]", i), {31'd0, sif.done_o},  32'd0);
        end
        check_eq("t1_hit_final", {24'd0, sif.hit_cnt_o}, OV ? 32'd3 : 32'd2);
        step();
        check_eq("t1_y_idle",    {31'd0, sif.y_o},    32'd0);
        check_eq("t1_busy_arm",  {31'd0, sif.busy_o}, 32'd1);
        do_abort();
        check_eq("t1_busy_ab",   {31'd0, sif.busy_o}, 32'd0);
        check_eq("t1_done_ab",   {31'd0, sif.done_o}, 32'd0);
        step();
        check_eq("t1_hit_hold",  {24'd0, sif.hit_cnt_o}, {24'd0, eh});

        // ---- T2: max_hits = 2, done after second y ----
        do_start(8'h05, 4'd3, 8'd2);
        check_eq("t2_hit_clr", {24'd0, sif.hit_cnt_o}, 32'd0);
        for (int i = 0; i < 13; i++) begin
            smp(stream_a[i], 1'b1);
            check_eq($sformatf("t2_y[%0d]", i),    {31'd0, sif.y_o},
                     ((i == 5) || (i == 10)) ? 32'd1 : 32'd0);
            check_eq($sformatf("t2_done[%0d]", i), {31'd0, sif.done_o},
                     (i == 11) ? 32'd1 : 32'd0);
            check_eq($sformatf("t2_busy[%0d]", i), {31'd0, sif.busy_o},
                     (i < 10) ? 32'd1 : 32'd0);
            check_eq($sformatf("t2_hit[%0d]", i),  {24'd0, sif.hit_cnt_o},
                     (i < 5) ? 32'd0 : ((i < 10) ? 32'd1 : 32'd2));
        end
        step();
        check_eq("t2_hit_hold", {24'd0, sif.hit_cnt_o}, 32'd2);

        // ---- T3: x_valid gaps, invalid x and ignored start while armed ----
        do_start(8'h05, 4'd3, 8'd0);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                sif.start_i   = 1'b1;
                sif.pat_i     = 8'h00;
                sif.pat_len_i = 4'd1;
            end
            smp(t3_x[i], t3_v[i]);
            sif.start_i   = 1'b0;
            sif.pat_i     = 8'h05;
            sif.pat_len_i = 4'd3;
            check_eq($sformatf("t3_y[%0d]", i), {31'd0, sif.y_o},
                     (i == 4) ? 32'd1 : 32'd0);
        end
        check_eq("t3_hit", {24'd0, sif.hit_cnt_o}, 32'd1);
        sif.x_i = 1'b1;
        step();
        check_eq("t3_y_inv", {31'd0, sif.y_o}, 32'd0);
        do_abort();

        // ---- T4: abort on the completing match at the hit limit ----
        do_start(8'h05, 4'd3, 8'd1);
        smp(1'b1, 1'b1);
        smp(1'b0, 1'b1);
        sif.abort_i = 1'b1;
        smp(1'b1, 1'b1);
        sif.abort_i = 1'b0;
        check_eq("t4_y",     {31'd0, sif.y_o},    32'd1);
        check_eq("t4_hit",   {24'd0, sif.hit_cnt_o}, 32'd1);
        check_eq("t4_busy",  {31'd0, sif.busy_o}, 32'd0);
        check_eq("t4_done0", {31'd0, sif.done_o}, 32'd0);
        step();
        check_eq("t4_done1", {31'd0, sif.done_o}, 32'd0);
        check_eq("t4_y1",    {31'd0, sif.y_o},    32'd0);
        step();
        check_eq("t4_done2", {31'd0, sif.done_o}, 32'd0);
        check_eq("t4_hit2",  {24'd0, sif.hit_cnt_o}, 32'd1);

        // ---- T5: asynchronous reset mid-session, then restart ----
        do_start(8'h05, 4'd3, 8'd0);
        for (int i = 0; i < 11; i++) begin
            smp(stream_a[i], 1'b1);
        end
        check_eq("t5_hit_pre", {24'd0, sif.hit_cnt_o}, 32'd2);
        check_eq("t5_y_pre",   {31'd0, sif.y_o},    32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t5_rst_y",    {31'd0, sif.y_o},    32'd0);
        check_eq("t5_rst_busy", {31'd0, sif.busy_o}, 32'd0);
        check_eq("t5_rst_done", {31'd0, sif.done_o}, 32'd0);
        check_eq("t5_rst_hit",  {24'd0, sif.hit_cnt_o}, 32'd0);
        rst = 1'b0;
        step();
        check_eq("t5_busy_post", {31'd0, sif.busy_o}, 32'd0);

        // pat_len 0 clamps to 1: every x=1 sample is a match
        do_start(8'h01, 4'd0, 8'd0);
        check_eq("t5_busy_rs", {31'd0, sif.busy_o}, 32'd1);
        smp(1'b1, 1'b1);
        check_eq("t5_len0_y0", {31'd0, sif.y_o},    32'd1);
        smp(1'b0, 1'b1);
        check_eq("t5_len0_y1", {31'd0, sif.y_o},    32'd0);
        smp(1'b1, 1'b1);
        check_eq("t5_len0_y2", {31'd0, sif.y_o},    32'd1);
        check_eq("t5_len0_hit", {24'd0, sif.hit_cnt_o}, 32'd2);
        do_abort();

        // pat_len 15 clamps to 8: A5 needs all eight samples
        do_start(8'hA5, 4'd15, 8'd0);
        a5 = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            smp(a5[i], 1'b1);
            check_eq($sformatf("t5_len15_y[%0d]", i), {31'd0, sif.y_o},
                     (i == 0) ? 32'd1 : 32'd0);
        end
        check_eq("t5_len15_hit", {24'd0, sif.hit_cnt_o}, 32'd1);
        do_abort();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
